// File: rtl/dest_reg_pipe.sv
// Destination-register tracking pipe: one {dest, wreg} entry per stage (EX..WB),
// with per-stage source matching and a youngest-hit forward select.
module dest_reg_cmp #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] dest,
    input  logic             we,
    input  logic [REG_W-1:0] rs_q,
    input  logic [REG_W-1:0] rt_q,
    output logic             hit_rs,
    output logic             hit_rt
);
    // $0 is never a real producer, so a zero source never matches
    assign hit_rs = we && (dest == rs_q) && (rs_q != '0);
    assign hit_rt = we && (dest == rt_q) && (rt_q != '0);
endmodule

module dest_reg_pipe #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       rt,
    input  logic [REG_W-1:0]       rd,
    input  logic [1:0]             dst_sel,
    input  logic                   wreg_in,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [REG_W-1:0]       rs_q,
    input  logic [REG_W-1:0]       rt_q,
    output logic [DEPTH*REG_W-1:0] dest_o,
    output logic [DEPTH-1:0]       wreg_o,
    output logic [DEPTH-1:0]       hit_rs,
    output logic [DEPTH-1:0]       hit_rt,
    output logic [3:0]             fwd_rs,
    output logic [3:0]             fwd_rt
);
    logic [DEPTH-1:0][REG_W-1:0] dest_q;
    logic [DEPTH-1:0]            we_q;
    logic [REG_W-1:0]            sel_dest;
    logic                        sel_we;
    logic                        cap_we;

    always_comb begin
        sel_dest = '0;
        sel_we   = 1'b0;
        case (dst_sel)
            2'b00:   begin sel_dest = rd;               sel_we = wreg_in; end
            2'b01:   begin sel_dest = rt;               sel_we = wreg_in; end
            2'b10:   begin sel_dest = REG_W'(LINK_REG); sel_we = wreg_in; end
            default: begin sel_dest = '0;               sel_we = 1'b0;    end
        endcase
    end

    assign cap_we = sel_we && (sel_dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_q <= '0;
            we_q   <= '0;
        end else begin
            if (flush) begin
                dest_q[0] <= '0;
                we_q[0]   <= 1'b0;
            end else if (!stall) begin
                dest_q[0] <= sel_dest;
                we_q[0]   <= cap_we;
            end
            // a held stage 0 must not also be copied forward, so stage 1 takes a bubble
            for (int k = 1; k < DEPTH; k++) begin
                if (k == 1 && stall && !flush) begin
                    dest_q[k] <= '0;
                    we_q[k]   <= 1'b0;
                end else begin
                    dest_q[k] <= dest_q[k-1];
                    we_q[k]   <= we_q[k-1];
                end
            end
        end
    end

    assign dest_o = dest_q;
    assign wreg_o = we_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        dest_reg_cmp #(.REG_W(REG_W)) u_cmp (
            .dest   (dest_q[g]),
            .we     (we_q[g]),
            .rs_q   (rs_q),
            .rt_q   (rt_q),
            .hit_rs (hit_rs[g]),
            .hit_rt (hit_rt[g])
        );
    end

    // scan oldest to youngest so the youngest hit is the one left standing
    always_comb begin
        fwd_rs = '0;
        fwd_rt = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_rs[k]) fwd_rs = 4'(k + 1);
            if (hit_rt[k]) fwd_rt = 4'(k + 1);
        end
    end
endmodule

// File: doc/dest_reg_pipe.md
DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

Interface
REQ-001 Parameter REG_W, default 5, register-specifier width.
REQ-002 Parameter DEPTH, default 3, number of tracked pipeline stages (stage 0 = EX, stage DEPTH-1 = WB); legal range 1..8.
REQ-003 Parameter LINK_REG, default 31, destination used for link (jal/jalr) writes.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rt  input  REG_W  instruction bits 20:16 from decode.
REQ-007 rd  input  REG_W  instruction bits 15:11 from decode.
REQ-008 dst_sel  input  2  00 = rd, 01 = rt, 10 = LINK_REG, 11 = no destination.
REQ-009 wreg_in  input  1  decoded instruction writes the register file.
REQ-010 stall  input  1  hold the decode-to-stage-0 transfer this cycle.
REQ-011 flush  input  1  kill the instruction entering stage 0 this cycle.
REQ-012 rs_q, rt_q  input  REG_W each  source specifiers of the instruction currently in decode.
REQ-013 dest_o  output  DEPTH*REG_W  destination register per stage, stage k in bits [k*REG_W +: REG_W].
REQ-014 wreg_o  output  DEPTH  write-enable per stage.
REQ-015 hit_rs, hit_rt  output  DEPTH each  per-stage match against rs_q / rt_q.
REQ-016 fwd_rs, fwd_rt  output  4 each  0 = no match, else (index of youngest matching stage)+1.

Function
REQ-017 Combinational select: sel_dest = rd, rt or LINK_REG per dst_sel; sel_we = wreg_in when dst_sel is 00, 01 or 10, else 0.
REQ-018 If sel_dest == 0, captured write-enable is forced to 0 (writes to $0 never tracked).
REQ-019 Normal cycle (stall=0, flush=0): stage 0 captures {sel_dest, sel_we}; stage k captures stage k-1 for k=1..DEPTH-1; stage DEPTH-1 contents retire.
REQ-020 Bubble = {dest=0, wreg=0}.
REQ-021 stall=1, flush=0: stage 0 holds its value; stage 1 captures a bubble; stages 2..DEPTH-1 advance normally.
REQ-022 flush=1 (regardless of stall): stage 0 captures a bubble; stages 1..DEPTH-1 advance normally.
REQ-023 DEPTH=1 with stall=1: stage 0 holds; no bubble insertion occurs.
REQ-024 Latency: decode value visible on dest_o/wreg_o stage 0 one cycle after capture, stage k after k+1 cycles absent stalls.
REQ-025 hit_rs[k] = wreg_o[k] AND dest stage k == rs_q AND rs_q != 0; hit_rt likewise with rt_q; purely combinational from current state and inputs.
REQ-026 fwd_rs/fwd_rt select the lowest-index (youngest) hitting stage; multiple hits never produce an older stage.
REQ-027 Outputs dest_o, wreg_o are registered; hit/fwd outputs carry no additional cycle of latency.

Reset
REQ-028 rst_n low asynchronously clears every stage to a bubble; dest_o=0, wreg_o=0, hit_*=0, fwd_*=0 while held.
REQ-029 Reset asserted mid-operation discards all in-flight entries; first capture occurs on the first rising edge with rst_n high.

Verification
REQ-030 Reset then dst_sel=00, rd=8, rt=9, wreg_in=1, one edge -> stage 0 dest=8, wreg=1; two more edges (bubbles) -> stage 2 dest=8.
REQ-031 dst_sel=10, wreg_in=1 -> stage 0 dest=31 wreg=1; dst_sel=11 wreg_in=1 -> stage 0 wreg=0; dst_sel=01 rt=0 -> wreg=0.
REQ-032 Stage 0 holds dest=5; assert stall one cycle -> stage 0 still 5, stage 1 bubble, former stage 1 moves to stage 2.
REQ-033 stall=1 and flush=1 together -> stage 0 bubble, stage 1 receives former stage 0 contents.
REQ-034 Stages 0 and 2 both dest=7 wreg=1, rs_q=7 -> hit_rs=101b, fwd_rs=1; rs_q=0 with any dest=0 entry -> hit_rs=000b, fwd_rs=0.
REQ-035 Pulse rst_n low between clock edges with all stages valid -> wreg_o=000b immediately, before next edge.
